// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, centralFSM key codes and the row/col-to-code map
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;
  localparam logic [3:0] KEY_STOP   = 4'hA;
  localparam logic [3:0] KEY_RESUME = 4'hB;
  localparam logic [3:0] KEY_UP     = 4'hC;
  localparam logic [3:0] KEY_DOWN   = 4'hD;
  localparam logic [3:0] KEY_ESCAPE = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-event outputs to centralFSM
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] buttonBus;
  logic       pressed;
  logic       key_held;
  modport master (input col_n, output row_n, buttonBus, pressed, key_held);
  modport slave  (output col_n, input row_n, buttonBus, pressed, key_held);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for the raw keypad columns, idles high
module sync_2ff (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] m_q, s_q;
  // metastability chain; reset to the pulled-up (no key) level
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= 4'hF;
      s_q <= 4'hF;
    end else begin
      m_q <= d_i;
      s_q <= m_q;
    end
  end
  assign q_o = s_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan/debounce FSM; define KEYPAD_AUTOREPEAT_EN for UP/DOWN auto-repeat
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input logic clk,
  input logic rst,
  keypad_scanner_if.master kp
);
  localparam int CW = $clog2((SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES) + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat_cfg
    $error("keypad_scanner: REPEAT_DELAY must be >= REPEAT_PERIOD >= 1");
  end

  state_e        state_q;
  logic [1:0]    row_q, col_q, col_idx;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [3:0]    cols, low, pat_q, code_q;
  logic          pressed_q, held_q, one_low, accept, rep_fire;

  sync_2ff u_sync (.clk(clk), .rst(rst), .d_i(kp.col_n), .q_o(cols));

  // single-low-column detection and the acceptance condition
  always_comb begin
    low     = ~cols;
    one_low = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    col_idx = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    accept  = (state_q == DEBOUNCE) && (cols == pat_q) && (cnt_q == DEB_LAST);
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rep_q, rep_d;
  // after the first repeat, reloading to DELAY-PERIOD spaces later strobes PERIOD apart
  always_comb begin
    rep_fire = (state_q == HELD) && (code_q == KEY_UP || code_q == KEY_DOWN) && (rep_q == REP_LAST);
    rep_d    = accept ? '0 : rep_fire ? REP_RELOAD :
               (state_q == HELD && rep_q != RW'(REPEAT_DELAY)) ? rep_q + 1'b1 : rep_q;
  end
  // repeat timer, counts only while the key sits in HELD
  always_ff @(posedge clk) begin
    rep_q <= rst ? '0 : rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // scan / debounce / hold / release sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      cnt_q     <= '0;
      pat_q     <= 4'hF;
      code_q    <= 4'h0;
      pressed_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      case (state_q)
        SCAN:
          if (cnt_q != SCAN_LAST) cnt_q <= cnt_inc;
          else begin
            cnt_q <= '0;
            if (one_low) begin
              state_q <= DEBOUNCE;
              pat_q   <= cols;
              col_q   <= col_idx;
            end else row_q <= row_q + 1'b1;
          end
        DEBOUNCE:
          if (cols != pat_q) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            row_q   <= row_q + 1'b1;
          end else begin
            cnt_q <= cnt_inc;
            if (accept) begin
              state_q   <= HELD;
              code_q    <= key_code(row_q, col_q);
              pressed_q <= 1'b1;
              held_q    <= 1'b1;
            end
          end
        HELD:
          if (&cols) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end else pressed_q <= rep_fire;
        RELEASE:
          if (!(&cols)) state_q <= HELD;
          else if (cnt_q == DEB_LAST) begin
            state_q <= SCAN;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            row_q   <= row_q + 1'b1;
          end else cnt_q <= cnt_inc;
        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.row_n     = ~(4'b0001 << row_q);
  assign kp.buttonBus = code_q;
  assign kp.pressed   = pressed_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios checked against a key-event model
module tb_keypad_scanner;
  import keypad_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] keys;
  logic allow;
  logic [3:0] exp_code;
  logic [3:0] prev_bus = 4'h0;
  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int cyc = 0;
  int strobe_cyc[$];
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(64), .REPEAT_PERIOD(16))
    dut (.clk(clk), .rst(rst), .kp(kp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // keypad matrix: a closed key shorts its row to its column
  always_comb begin
    kp.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.row_n[r]) kp.col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe(input string name, input int bound);
    int s0 = strobes;
    int i = 0;
    while (strobes == s0 && i < bound) begin
      tick(1);
      i++;
    end
    check(name, 32'(strobes > s0), 32'd1);
  endtask

  // per-cycle checks: one row driven, strobes only when expected and carrying the model's code
  always @(negedge clk) begin
    check("row_onehot", 32'($countones(~kp.row_n)), 32'd1);
    if (!rst) begin
      if (kp.pressed) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        check("strobe_allowed", 32'(allow), 32'd1);
        check("strobe_code", 32'(kp.buttonBus), 32'(exp_code));
        check("strobe_held", 32'(kp.key_held), 32'd1);
      end else check("bus_stable", 32'(kp.buttonBus), 32'(prev_bus));
    end
    prev_bus = kp.buttonBus;
  end

  initial begin
    int s0, a, found;
    int exp_off[$];
    rst = 1'b1;
    keys = '0;
    allow = 1'b0;
    exp_code = 4'h0;
    tick(3);
    check("rst_row", 32'(kp.row_n), 32'hE);
    check("rst_bus", 32'(kp.buttonBus), 32'h0);
    check("rst_pressed", 32'(kp.pressed), 32'h0);
    check("rst_held", 32'(kp.key_held), 32'h0);
    rst = 1'b0;
    tick(5);

    // key 5 held 120 clocks: one strobe, held until release debounce completes
    s0 = strobes;
    allow = 1'b1;
    exp_code = keymap[5];
    strobe_cyc.delete();
    keys[5] = 1'b1;
    wait_strobe("s1_strobe", 200);
    a = strobe_cyc.size() > 0 ? strobe_cyc[0] : cyc;
    while (cyc < a + 120) tick(1);
    check("s1_bus", 32'(kp.buttonBus), 32'h5);
    check("s1_held", 32'(kp.key_held), 32'd1);
    keys = '0;
    tick(8);
    check("s1_held_after8", 32'(kp.key_held), 32'd1);
    tick(4);
    check("s1_released", 32'(kp.key_held), 32'd0);
    check("s1_count", 32'(strobes - s0), 32'd1);
    check("s1_bus_kept", 32'(kp.buttonBus), 32'h5);
    tick(20);

    // key D bouncing 3 low / 2 high for 20 clocks, then steady
    s0 = strobes;
    allow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      keys[15] = 1'b1;
      tick(3);
      keys[15] = 1'b0;
      tick(2);
    end
    check("s2_no_bounce_strobe", 32'(strobes - s0), 32'd0);
    allow = 1'b1;
    exp_code = keymap[15];
    keys[15] = 1'b1;
    wait_strobe("s2_strobe", 200);
    tick(20);
    check("s2_bus", 32'(kp.buttonBus), 32'hD);
    keys = '0;
    tick(20);
    check("s2_count", 32'(strobes - s0), 32'd1);

    // two keys on row 0: ignored until one is released
    s0 = strobes;
    allow = 1'b0;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    tick(64);
    check("s3_no_strobe", 32'(strobes - s0), 32'd0);
    allow = 1'b1;
    exp_code = keymap[0];
    keys[1] = 1'b0;
    wait_strobe("s3_strobe", 200);
    tick(5);
    check("s3_bus", 32'(kp.buttonBus), 32'h1);
    check("s3_count", 32'(strobes - s0), 32'd1);
    keys = '0;
    tick(20);

    // 9 pressed while 5 is held is ignored; 9 alone is then accepted
    s0 = strobes;
    allow = 1'b1;
    exp_code = keymap[5];
    keys[5] = 1'b1;
    wait_strobe("s4_strobe5", 200);
    allow = 1'b0;
    tick(10);
    keys[10] = 1'b1;
    tick(40);
    check("s4_no_strobe9", 32'(strobes - s0), 32'd1);
    keys = '0;
    tick(25);
    allow = 1'b1;
    exp_code = keymap[10];
    keys[10] = 1'b1;
    wait_strobe("s4_strobe9", 200);
    tick(5);
    check("s4_bus", 32'(kp.buttonBus), 32'h9);
    check("s4_count", 32'(strobes - s0), 32'd2);
    keys = '0;
    tick(20);

    // reset three clocks into debouncing key 4; key still down is re-detected
    s0 = strobes;
    allow = 1'b0;
    keys[4] = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (dut.state_q == DEBOUNCE) found = 1;
      else tick(1);
    end
    check("s5_debounce_seen", 32'(found), 32'd1);
    tick(3);
    rst = 1'b1;
    tick(2);
    check("s5_rst_row", 32'(kp.row_n), 32'hE);
    check("s5_rst_bus", 32'(kp.buttonBus), 32'h0);
    check("s5_rst_pressed", 32'(kp.pressed), 32'h0);
    check("s5_rst_held", 32'(kp.key_held), 32'h0);
    rst = 1'b0;
    check("s5_no_strobe", 32'(strobes - s0), 32'd0);
    allow = 1'b1;
    exp_code = keymap[4];
    wait_strobe("s5_strobe", 200);
    tick(5);
    check("s5_bus", 32'(kp.buttonBus), 32'h4);
    check("s5_count", 32'(strobes - s0), 32'd1);
    keys = '0;
    tick(20);

    // key C held 120 clocks: repeats only when auto-repeat is built in
    exp_off.push_back(0);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int t = 64; t < 120; t += 16) exp_off.push_back(t);
`endif
    allow = 1'b1;
    exp_code = keymap[11];
    strobe_cyc.delete();
    keys[11] = 1'b1;
    wait_strobe("s6_strobe", 200);
    a = strobe_cyc.size() > 0 ? strobe_cyc[0] : cyc;
    while (cyc < a + 120) tick(1);
    keys = '0;
    tick(20);
    check("s6_count", 32'(strobe_cyc.size()), 32'(exp_off.size()));
    for (int i = 0; i < exp_off.size() && i < strobe_cyc.size(); i++)
      check("s6_offset", 32'(strobe_cyc[i] - a), 32'(exp_off[i]));
    check("s6_bus", 32'(kp.buttonBus), 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
